// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and the
// bit-timing helper both ends use, so a looped-back link agrees on baud timing.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_STATE_IDLE,
        RX_STATE_START,
        RX_STATE_DATA,
        RX_STATE_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_LOAD,
        STATE_SEND
    } tx_state_t;

    // Cycles per serial bit; integer division, truncating any remainder.
    function automatic int unsigned clocks_per_bit(
        input int unsigned clock_frequency,
        input int unsigned baud_rate
    );
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/transmitter_if.sv
// Transmitter bus bundle: TX FIFO read port plus the serial line and busy flag.
//   din   : FIFO read data, valid the cycle after re
//   empty : FIFO empty flag
//   re    : FIFO read strobe (single-cycle pulse)
//   dout  : serial TX line, idles high
//   busy  : frame being loaded or sent
// master = transmitter side, slave = FIFO/pad side.
interface transmitter_if #(
    parameter int unsigned WORD_WIDTH = 32'd8
);
    logic [WORD_WIDTH-1:0] din;
    logic                  empty;
    logic                  re;
    logic                  dout;
    logic                  busy;

    modport master (
        input  din,
        input  empty,
        output re,
        output dout,
        output busy
    );

    modport slave (
        output din,
        output empty,
        input  re,
        input  dout,
        input  busy
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter shared by the UART ends.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : synchronous clear to zero (has priority over enable)
//   enable   : count this cycle; wraps to zero after terminal count
//   tc_c     : combinational terminal count (count == CLOCKS_PER_BIT-1)
module uart_bit_timer #(
    parameter int unsigned CLOCKS_PER_BIT = 32'd434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);
    localparam int unsigned TIMER_WIDTH = 32;

    logic [TIMER_WIDTH-1:0] count_q;

    assign tc_c = (count_q == TIMER_WIDTH'(CLOCKS_PER_BIT - 1));

    // Counter wraps at terminal count, so it never exceeds CLOCKS_PER_BIT-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            if (tc_c) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + TIMER_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/transmitter.sv
// UART transmitter: pops words from a standard (registered-read) TX FIFO and
// sends each as start bit, WORD_WIDTH data bits LSB first, STOP_BITS stop bits.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : transmitter_if master (din/empty/re FIFO port, dout line, busy)
module transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
    parameter int unsigned BAUD_RATE       = 32'd230400,
    parameter int unsigned WORD_WIDTH      = 32'd8,
    parameter int unsigned STOP_BITS       = 32'd1
) (
    input  logic            clk,
    input  logic            rst,
    transmitter_if.master   bus
);
    localparam int unsigned CLOCKS_PER_BIT = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned FRAME_BITS     = WORD_WIDTH + 1 + STOP_BITS;
    localparam int unsigned CNT_WIDTH      = $clog2(FRAME_BITS + 1);

    if (CLOCKS_PER_BIT < 2) begin : g_cpb_check
        $error("transmitter: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_stop_check
        $error("transmitter: STOP_BITS must be 1 or 2");
    end

    tx_state_t              state_q, state_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [CNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   dout_q;
    logic                   busy_q;
    logic                   re_c;
    logic                   timer_clear_c;
    logic                   timer_enable_c;
    logic                   timer_tc_c;

    uart_bit_timer #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear_c),
        .enable (timer_enable_c),
        .tc_c   (timer_tc_c)
    );

    // Next-state, shift register and FIFO strobe.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        re_c           = 1'b0;
        timer_clear_c  = 1'b0;
        timer_enable_c = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (!bus.empty) begin
                    re_c    = 1'b1;
                    state_d = STATE_LOAD;
                end
            end
            STATE_LOAD: begin
                shift_d       = {{STOP_BITS{1'b1}}, bus.din, 1'b0};
                bit_cnt_d     = '0;
                timer_clear_c = 1'b1;
                state_d       = STATE_SEND;
            end
            STATE_SEND: begin
                timer_enable_c = 1'b1;
                if (timer_tc_c) begin
                    shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
                    if (bit_cnt_q == CNT_WIDTH'(FRAME_BITS - 1)) begin
                        state_d = STATE_IDLE;
                    end
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // dout is registered from the next shift value so the start bit appears
    // the cycle after LOAD; it always equals shift_q[0] and never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= STATE_IDLE;
            shift_q   <= '1;
            bit_cnt_q <= '0;
            dout_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            dout_q    <= shift_d[0];
            busy_q    <= (state_d != STATE_IDLE);
        end
    end

    assign bus.re   = re_c;
    assign bus.dout = dout_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for transmitter: cycle-exact line checks per frame plus a
// scoreboard of words decoded off the line against words written to the FIFO.
module tb_transmitter;
    localparam int unsigned CPB = 434;   // 100 MHz / 230400 baud, truncated

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    transmitter_if #(.WORD_WIDTH(8)) if1 ();
    transmitter_if #(.WORD_WIDTH(8)) if2 ();

    transmitter #(
        .CLOCK_FREQUENCY(32'd100_000_000),
        .BAUD_RATE      (32'd230400),
        .WORD_WIDTH     (32'd8),
        .STOP_BITS      (32'd1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.master)
    );

    transmitter #(
        .CLOCK_FREQUENCY(32'd100_000_000),
        .BAUD_RATE      (32'd230400),
        .WORD_WIDTH     (32'd8),
        .STOP_BITS      (32'd2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.master)
    );

    // FIFO models: registered read data, valid the cycle after re.
    logic [7:0] mem1 [0:63];
    logic [7:0] mem2 [0:63];
    int pushed1 = 0, popped1 = 0, pushed2 = 0, popped2 = 0;

    assign if1.empty = (pushed1 == popped1);
    assign if2.empty = (pushed2 == popped2);

    always @(posedge clk) begin
        if (if1.re) begin
            if1.din <= mem1[popped1[5:0]];
            popped1 <= popped1 + 1;
        end
        if (if2.re) begin
            if2.din <= mem2[popped2[5:0]];
            popped2 <= popped2 + 1;
        end
    end

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    // Line monitor for dut1: mid-bit sampling, frames cut by reset are dropped.
    always begin : mon1
        logic [7:0] w;
        logic       ok;
        @(negedge clk);
        if (!rst && if1.dout === 1'b0) begin
            ok = 1'b1;
            w  = '0;
            repeat (CPB / 2) begin @(negedge clk); if (rst) ok = 1'b0; end
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) begin @(negedge clk); if (rst) ok = 1'b0; end
                w[i] = if1.dout;
            end
            repeat (CPB) begin @(negedge clk); if (rst) ok = 1'b0; end
            if (if1.dout !== 1'b1) ok = 1'b0;
            if (ok) rx_q.push_back(w);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic dout_of(input int sel);
        return (sel == 1) ? if1.dout : if2.dout;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 1) ? if1.busy : if2.busy;
    endfunction

    function automatic logic re_of(input int sel);
        return (sel == 1) ? if1.re : if2.re;
    endfunction

    // Expected line level k cycles after the start bit begins.
    function automatic logic exp_bit(input logic [7:0] w, input int k);
        int idx;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[3'(idx - 1)];
        return 1'b1;
    endfunction

    task automatic push1(input logic [7:0] w, input bit track);
        mem1[pushed1[5:0]] = w;
        pushed1 = pushed1 + 1;
        if (track) exp_q.push_back(w);
    endtask

    task automatic push2(input logic [7:0] w);
        mem2[pushed2[5:0]] = w;
        pushed2 = pushed2 + 1;
    endtask

    // Called in the cycle where re must be high; returns in the first cycle
    // after the last stop bit.
    task automatic check_frame(input int sel, input logic [7:0] w, input int stop_bits,
                               input string tag);
        int frame_cycles;
        int bad_line, bad_busy, bad_re;
        frame_cycles = (9 + stop_bits) * CPB;
        bad_line = 0;
        bad_busy = 0;
        bad_re   = 0;
        chk_bit({tag, "_re_pulse"}, re_of(sel), 1'b1);
        chk_bit({tag, "_idle_high"}, dout_of(sel), 1'b1);
        @(negedge clk);
        chk_bit({tag, "_load_re"}, re_of(sel), 1'b0);
        chk_bit({tag, "_load_busy"}, busy_of(sel), 1'b1);
        chk_bit({tag, "_load_high"}, dout_of(sel), 1'b1);
        for (int k = 0; k < frame_cycles; k++) begin
            @(negedge clk);
            if (dout_of(sel) !== exp_bit(w, k)) bad_line++;
            if (busy_of(sel) !== 1'b1) bad_busy++;
            if (re_of(sel) !== 1'b0) bad_re++;
        end
        chk({tag, "_line_errs"}, bad_line, 0);
        chk({tag, "_busy_errs"}, bad_busy, 0);
        chk({tag, "_re_errs"}, bad_re, 0);
        @(negedge clk);
    endtask

    task automatic sb_check(input string tag);
        chk({tag, "_sb_count"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            chk({tag, "_sb_word"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin : watchdog
        #800_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lows, res, n;
        logic [7:0] w;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk_bit("rst_dout", if1.dout, 1'b1);
        chk_bit("rst_re", if1.re, 1'b0);
        chk_bit("rst_busy", if1.busy, 1'b0);
        chk_bit("rst_dout2", if2.dout, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Empty FIFO: line stays high, no reads.
        lows = 0; res = 0;
        repeat (50) begin
            @(negedge clk);
            if (if1.dout !== 1'b1) lows++;
            if (if1.re !== 1'b0) res++;
        end
        chk("idle_lows", lows, 0);
        chk("idle_re", res, 0);

        // Single word.
        @(negedge clk);
        push1(8'h55, 1'b1);
        #1;
        check_frame(1, 8'h55, 1, "single");
        chk_bit("single_end_busy", if1.busy, 1'b0);
        chk_bit("single_end_dout", if1.dout, 1'b1);
        chk_bit("single_end_re", if1.re, 1'b0);
        chk("single_reads", popped1, 1);
        sb_check("single");

        // Back-to-back words: second frame starts 2 cycles after the first.
        @(negedge clk);
        push1(8'hA3, 1'b1);
        push1(8'h0F, 1'b1);
        #1;
        check_frame(1, 8'hA3, 1, "b2b_first");
        check_frame(1, 8'h0F, 1, "b2b_second");
        chk_bit("b2b_end_busy", if1.busy, 1'b0);
        chk("b2b_reads", popped1, 3);
        sb_check("b2b");

        // Two stop bits.
        @(negedge clk);
        push2(8'hFF);
        #1;
        check_frame(2, 8'hFF, 2, "stop2");
        chk_bit("stop2_end_busy", if2.busy, 1'b0);
        chk("stop2_reads", popped2, 1);

        // Reset during data bit 3 of 0x3C.
        @(negedge clk);
        push1(8'h3C, 1'b0);
        repeat (2 + 4 * CPB + 100) @(negedge clk);
        chk_bit("mid_pre_busy", if1.busy, 1'b1);
        chk_bit("mid_pre_dout", if1.dout, exp_bit(8'h3C, 4 * CPB + 99));
        #2 rst = 1'b1;
        #1;
        chk_bit("mid_rst_dout", if1.dout, 1'b1);
        chk_bit("mid_rst_busy", if1.busy, 1'b0);
        chk_bit("mid_rst_re", if1.re, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lows = 0; res = 0;
        repeat (3000) begin
            @(negedge clk);
            if (if1.dout !== 1'b1) lows++;
            if (if1.re !== 1'b0) res++;
        end
        chk("mid_after_lows", lows, 0);
        chk("mid_after_re", res, 0);
        chk("mid_reads", popped1, 4);
        sb_check("mid");

        // Random words through the scoreboard.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            w = 8'($urandom_range(0, 255));
            push1(w, 1'b1);
        end
        n = 0;
        while ((pushed1 != popped1 || if1.busy) && n < 25000) begin
            @(negedge clk);
            n++;
        end
        chk("rand_timeout", 32'(n >= 25000), 0);
        repeat (4) @(negedge clk);
        sb_check("rand");
        chk("total_reads", popped1, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
